// File: rtl/acc_apb_sequencer.sv
// acc_apb_sequencer: APB master that runs one complete matrix-accelerator job
// (enable write, operand writes, result reads, disable write).
// Ports: HCLK/HRESETn clock and async active-low reset; cmd_valid/cmd_ready job
// start; in_valid/in_ready/in_data operand stream; out_valid/out_ready/out_data
// result stream; busy/done/err status; PADDR/PWDATA/PWRITE/PSEL/PENABLE master
// outputs; PRDATA/PREADY/PSLVERR slave responses. All outputs are registered.
module acc_apb_sequencer #(
    parameter int                        APB_ADDR_WIDTH = 13,
    parameter int                        N_WORDS        = 16,
    parameter int                        N_RESULTS      = 4,
    parameter logic [APB_ADDR_WIDTH-1:0] DATA_BASE      = 13'h004,
    parameter logic [APB_ADDR_WIDTH-1:0] RES_BASE       = 13'h100,
    parameter logic [APB_ADDR_WIDTH-1:0] END_ADDR       = 13'h008,
    parameter int                        TIMEOUT        = 1023
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [3:0] {
        IDLE,
        EN_SETUP,
        EN_ACC,
        WR_WAIT,
        WR_SETUP,
        WR_ACC,
        RD_SETUP,
        RD_ACC,
        RD_HOLD,
        END_SETUP,
        END_ACC,
        FINISH
    } state_t;

    localparam logic [8:0] LAST_WORD = 9'(N_WORDS);
    localparam logic [8:0] LAST_RES  = 9'(N_RESULTS);
    localparam logic [9:0] TO_LAST   = 10'(TIMEOUT - 1);

    state_t state_q, state_d;

    logic [8:0] wcnt_q, wcnt_d;
    logic [8:0] rcnt_q, rcnt_d;
    logic [9:0] tcnt_q, tcnt_d;

    logic [APB_ADDR_WIDTH-1:0] paddr_d;
    logic [31:0]               pwdata_d;
    logic                      pwrite_d;
    logic [31:0]               out_data_d;
    logic                      err_d;

    logic sel_d, en_d;
    logic in_setup, in_acc;

    // Word addresses are truncated to the bus width.
    function automatic logic [APB_ADDR_WIDTH-1:0] word_addr(
        input logic [APB_ADDR_WIDTH-1:0] base,
        input logic [8:0]                idx
    );
        return base + APB_ADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign in_setup = state_q inside {EN_SETUP, WR_SETUP, RD_SETUP, END_SETUP};
    assign in_acc   = state_q inside {EN_ACC, WR_ACC, RD_ACC, END_ACC};

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        tcnt_d     = tcnt_q;
        paddr_d    = PADDR;
        pwdata_d   = PWDATA;
        pwrite_d   = PWRITE;
        out_data_d = out_data;
        err_d      = err;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = EN_SETUP;
                    err_d    = 1'b0;
                    wcnt_d   = '0;
                    rcnt_d   = '0;
                    paddr_d  = '0;
                    pwdata_d = 32'd1;
                    pwrite_d = 1'b1;
                end
            end
            EN_SETUP: state_d = EN_ACC;
            EN_ACC: begin
                if (PREADY) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (in_valid) begin
                    state_d  = WR_SETUP;
                    paddr_d  = word_addr(DATA_BASE, wcnt_q);
                    pwdata_d = in_data;
                    pwrite_d = 1'b1;
                end
            end
            WR_SETUP: state_d = WR_ACC;
            WR_ACC: begin
                if (PREADY) begin
                    wcnt_d = wcnt_q + 9'd1;
                    if (wcnt_q + 9'd1 == LAST_WORD) begin
                        state_d  = RD_SETUP;
                        paddr_d  = word_addr(RES_BASE, rcnt_q);
                        pwrite_d = 1'b0;
                    end else begin
                        state_d = WR_WAIT;
                    end
                end
            end
            RD_SETUP: state_d = RD_ACC;
            RD_ACC: begin
                if (PREADY) begin
                    state_d    = RD_HOLD;
                    out_data_d = PRDATA;
                    rcnt_d     = rcnt_q + 9'd1;
                end
            end
            RD_HOLD: begin
                if (out_ready) begin
                    if (rcnt_q == LAST_RES) begin
                        state_d  = END_SETUP;
                        paddr_d  = END_ADDR;
                        pwdata_d = '0;
                        pwrite_d = 1'b1;
                    end else begin
                        state_d  = RD_SETUP;
                        paddr_d  = word_addr(RES_BASE, rcnt_q);
                        pwrite_d = 1'b0;
                    end
                end
            end
            END_SETUP: state_d = END_ACC;
            END_ACC: begin
                if (PREADY) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Shared ACCESS handling: error capture and the PREADY watchdog.
        // A timeout abandons the job without the disable write.
        if (in_setup) tcnt_d = '0;
        if (in_acc) begin
            if (PREADY) begin
                if (PSLVERR) err_d = 1'b1;
            end else if (tcnt_q == TO_LAST) begin
                err_d   = 1'b1;
                state_d = FINISH;
            end else begin
                tcnt_d = tcnt_q + 10'd1;
            end
        end

        sel_d = state_d inside {EN_SETUP, EN_ACC, WR_SETUP, WR_ACC,
                                RD_SETUP, RD_ACC, END_SETUP, END_ACC};
        en_d  = state_d inside {EN_ACC, WR_ACC, RD_ACC, END_ACC};
    end

    // Control outputs are decoded from the next state so they are
    // registered yet line up with the state they describe.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            tcnt_q    <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            tcnt_q    <= tcnt_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            PWRITE    <= pwrite_d;
            PSEL      <= sel_d;
            PENABLE   <= en_d;
            out_data  <= out_data_d;
            err       <= err_d;
            cmd_ready <= (state_d == IDLE);
            in_ready  <= (state_d == WR_WAIT);
            out_valid <= (state_d == RD_HOLD);
            busy      <= (state_d != IDLE);
            done      <= (state_d == FINISH);
        end
    end

endmodule

// File: tb/tb_acc_apb_sequencer.sv
// tb_acc_apb_sequencer: directed jobs against a small APB slave model,
// with write and result scoreboards.
module tb_acc_apb_sequencer;

    localparam int AW = 13;
    localparam int NW = 16;
    localparam int NR = 4;

    logic          HCLK      = 1'b0;
    logic          HRESETn   = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA    = '0;
    logic          PREADY    = 1'b0;
    logic          PSLVERR   = 1'b0;

    acc_apb_sequencer dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] wq[$];
    logic [31:0] rq[$];

    int          stall_addr  = -1;
    int          stall_n     = 0;
    bit          never_ready = 1'b0;
    int          slverr_idx  = -1;
    logic [31:0] rd_base     = 32'hA0;

    int          cyc = 0;
    int          done_cnt = 0;
    int          acc_n = 0;
    int          stalled_run = 0;
    int          aborted_run = 0;
    int          stall_now;
    int          jdx;
    logic [63:0] wexp;
    logic [AW-1:0] acc_addr;
    logic [31:0] acc_data;
    logic [31:0] prev_od;
    bit          prev_setup, prev_wait, prev_fin, prev_ov, prev_hs;

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    // Slave model and stream monitor, sampled mid-cycle.
    initial forever begin
        @(negedge HCLK);
        #1;
        if (!HRESETn) begin
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
            acc_n = 0;
            prev_setup = 0; prev_wait = 0; prev_fin = 0;
            prev_ov = 0; prev_hs = 0;
        end else begin
            if (done) done_cnt++;
            if (in_ready) chk("psel_idle_in_wait", PSEL, 1'b0);
            if (PENABLE) chk("access_after_setup", prev_setup || prev_wait, 1'b1);
            if (prev_fin) chk("penable_drop", PENABLE, 1'b0);
            if (prev_ov && !prev_hs) begin
                chk("out_valid_hold", out_valid, 1'b1);
                chk("out_data_hold", out_data, prev_od);
            end
            if (out_valid && out_ready) begin
                chk("result_expected", rq.size() > 0, 1'b1);
                if (rq.size() > 0) chk("result", out_data, rq.pop_front());
            end
            prev_ov = out_valid;
            prev_od = out_data;
            prev_hs = out_valid && out_ready;

            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
            prev_setup = PSEL && !PENABLE;
            prev_wait  = 1'b0;
            prev_fin   = 1'b0;
            if (PSEL && PENABLE) begin
                if (acc_n == 0) begin
                    acc_addr = PADDR;
                    acc_data = PWDATA;
                end else begin
                    chk("paddr_stable", PADDR, acc_addr);
                    chk("pwdata_stable", PWDATA, acc_data);
                end
                acc_n++;
                stall_now = (PWRITE && int'(PADDR) == stall_addr) ? stall_n : 0;
                if (!never_ready && acc_n > stall_now) begin
                    PREADY = 1'b1;
                    if (PWRITE) begin
                        chk("write_expected", wq.size() > 0, 1'b1);
                        if (wq.size() > 0) begin
                            wexp = wq.pop_front();
                            chk("apb_write", {32'(PADDR), PWDATA}, wexp);
                        end
                    end else begin
                        jdx = (int'(PADDR) - 'h100) / 4;
                        PRDATA  = rd_base + 32'(jdx);
                        PSLVERR = (jdx == slverr_idx);
                    end
                    if (stall_now > 0) stalled_run = acc_n;
                    acc_n = 0;
                    prev_fin = 1'b1;
                end else begin
                    prev_wait = 1'b1;
                end
            end else begin
                if (acc_n > 0) aborted_run = acc_n;
                acc_n = 0;
            end
        end
    end

    task automatic send_words(input logic [31:0] seed, input int gap);
        int t;
        for (int k = 0; k < NW; k++) begin
            t = 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge HCLK);
            end
            in_valid = 1'b1;
            in_data  = seed + 32'(k);
            while (!in_ready && t < 2000) begin
                @(negedge HCLK);
                t++;
            end
            if (t >= 2000) chk("in_handshake", in_ready, 1'b1);
            @(negedge HCLK);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_results(input int ostall);
        int t;
        if (ostall > 0) begin
            for (int j = 0; j < NR; j++) begin
                t = 0;
                out_ready = 1'b0;
                while (!out_valid && t < 2000) begin
                    @(negedge HCLK);
                    t++;
                end
                chk("out_valid_seen", out_valid, 1'b1);
                repeat (ostall) @(negedge HCLK);
                out_ready = 1'b1;
                @(negedge HCLK);
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string name, output int dcyc);
        int t;
        t = 0;
        while (!done && t < 4000) begin
            @(negedge HCLK);
            t++;
        end
        chk({name, "_done_seen"}, done, 1'b1);
        dcyc = cyc;
    endtask

    task automatic run_job(input string name, input logic [31:0] seed,
                           input int gap, input int ostall,
                           input logic exp_err, input bit chk_len);
        int acc_c;
        int dcyc;
        wq.push_back({32'h0, 32'd1});
        for (int k = 0; k < NW; k++)
            wq.push_back({32'(4 + 4 * k), seed + 32'(k)});
        wq.push_back({32'h8, 32'h0});
        for (int j = 0; j < NR; j++)
            rq.push_back(rd_base + 32'(j));
        done_cnt  = 0;
        out_ready = (ostall == 0);
        @(negedge HCLK);
        chk({name, "_cmd_ready_idle"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        @(negedge HCLK);
        cmd_valid = 1'b0;
        acc_c = cyc;
        chk({name, "_busy"}, busy, 1'b1);
        chk({name, "_cmd_ready_busy"}, cmd_ready, 1'b0);
        chk({name, "_err_cleared"}, err, 1'b0);
        fork
            send_words(seed, gap);
            recv_results(ostall);
            wait_done(name, dcyc);
        join
        if (chk_len) chk({name, "_done_cycle"}, 64'(dcyc - acc_c), 64'd64);
        chk({name, "_err"}, err, exp_err);
        @(negedge HCLK);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_busy_end"}, busy, 1'b0);
        chk({name, "_cmd_ready_end"}, cmd_ready, 1'b1);
        chk({name, "_writes_left"}, wq.size(), 0);
        chk({name, "_results_left"}, rq.size(), 0);
    endtask

    initial begin
        int acc_c;
        int dcyc;
        int t;

        #2 HRESETn = 1'b0;
        #1;
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_paddr", PADDR, '0);
        chk("rst_pwdata", PWDATA, '0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        run_job("zero_wait", 32'd1, 0, 0, 1'b0, 1'b1);

        slverr_idx = 1;
        run_job("slverr", 32'h1000_0000, 0, 0, 1'b1, 1'b0);
        slverr_idx = -1;
        chk("slverr_sticky", err, 1'b1);

        stall_addr = 'h00C;
        stall_n    = 5;
        rd_base    = 32'h5500;
        run_job("stall", 32'h2000_0040, 0, 0, 1'b0, 1'b0);
        chk("stall_access_len", stalled_run, 6);
        stall_addr = -1;
        stall_n    = 0;

        rd_base = 32'hBEE0;
        run_job("gaps", 32'hCAFE_0000, 3, 4, 1'b0, 1'b0);
        rd_base = 32'hA0;

        never_ready = 1'b1;
        done_cnt    = 0;
        @(negedge HCLK);
        cmd_valid = 1'b1;
        @(negedge HCLK);
        cmd_valid = 1'b0;
        acc_c = cyc;
        wait_done("timeout", dcyc);
        chk("timeout_err", err, 1'b1);
        chk("timeout_psel", PSEL, 1'b0);
        chk("timeout_cycle", 64'(dcyc - acc_c), 64'd1024);
        #2;
        chk("timeout_access_cycles", aborted_run, 1023);
        never_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            chk("timeout_bus_quiet", PSEL, 1'b0);
        end
        chk("timeout_done_count", done_cnt, 1);
        chk("timeout_busy", busy, 1'b0);
        chk("timeout_cmd_ready", cmd_ready, 1'b1);

        stall_addr = 'h010;
        stall_n    = 20;
        done_cnt   = 0;
        wq.push_back({32'h0, 32'd1});
        for (int k = 0; k < 3; k++)
            wq.push_back({32'(4 + 4 * k), 32'h77});
        in_data  = 32'h77;
        in_valid = 1'b1;
        @(negedge HCLK);
        cmd_valid = 1'b1;
        @(negedge HCLK);
        cmd_valid = 1'b0;
        t = 0;
        while (!(PENABLE && PADDR == 13'h010) && t < 500) begin
            @(negedge HCLK);
            t++;
        end
        chk("rst_mid_reached", PENABLE && PADDR == 13'h010, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", PSEL, 1'b0);
        chk("rst_mid_penable", PENABLE, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_writes", wq.size(), 0);
        in_valid   = 1'b0;
        stall_addr = -1;
        stall_n    = 0;
        repeat (2) @(negedge HCLK);
        chk("rst_mid_no_done", done_cnt, 0);
        HRESETn = 1'b1;

        run_job("post_reset", 32'h0BAD_F00D, 0, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end, required summary");
        $fatal(1, "watchdog");
    end

endmodule
